// File: rtl/ysyx22041405_lsu_pkg.sv
// ysyx22041405_lsu_pkg: shared size encodings, FSM states and WB message layout for the LSU.
package ysyx22041405_lsu_pkg;
  localparam logic [1:0] MEM_B = 2'd0;
  localparam logic [1:0] MEM_H = 2'd1;
  localparam logic [1:0] MEM_W = 2'd2;
  localparam int WB_DATA_W = 32;
  localparam int WB_ADDR_W = 5;
  localparam int WB_PC_W   = 32;
  localparam int WB_INST_W = 32;
  typedef enum logic [1:0] {IDLE, REQ, WAIT} lsu_state_e;
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] pc;
    logic [31:0] inst;
    logic        wen;
    logic [1:0]  size;
    logic        sext;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic        ebreak;
  } lsu_op_t;
  typedef struct packed {
    logic [WB_DATA_W-1:0] data;
    logic                 rf_we;
    logic [WB_ADDR_W-1:0] rf_waddr;
    logic [WB_PC_W-1:0]   pc;
    logic [WB_INST_W-1:0] inst;
    logic                 ebreak;
    logic                 misalign;
  } wb_msg_t;
  function automatic wb_msg_t op_result(lsu_op_t op, logic [WB_DATA_W-1:0] data);
    wb_msg_t w;
    w.data     = data;
    w.rf_we    = op.rf_we;
    w.rf_waddr = op.rf_waddr;
    w.pc       = op.pc;
    w.inst     = op.inst;
    w.ebreak   = op.ebreak;
    w.misalign = 1'b0;
    return w;
  endfunction
endpackage

// File: rtl/ysyx22041405_lsu_align.sv
// ysyx22041405_lsu_align: store lane replication/strobes and load lane extraction/extension.
module ysyx22041405_lsu_align
  import ysyx22041405_lsu_pkg::*;
(
  input  logic [1:0]  addr_i,
  input  logic [1:0]  size_i,
  input  logic        sext_i,
  input  logic [31:0] st_data_i,
  input  logic [31:0] rdata_i,
  output logic [31:0] wdata_o,
  output logic [3:0]  wstrb_o,
  output logic [31:0] ld_data_o
);
  logic [7:0]  b;
  logic [15:0] h;
  always_comb begin
    b = rdata_i[{addr_i, 3'b000} +: 8];
    h = addr_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    wdata_o = size_i == MEM_B ? {4{st_data_i[7:0]}} :
              size_i == MEM_H ? {2{st_data_i[15:0]}} : st_data_i;
    wstrb_o = size_i == MEM_B ? 4'b0001 << addr_i :
              size_i == MEM_H ? 4'b0011 << {addr_i[1], 1'b0} : 4'hF;
    ld_data_o = size_i == MEM_B ? {{24{sext_i & b[7]}}, b} :
                size_i == MEM_H ? {{16{sext_i & h[15]}}, h} : rdata_i;
  end
endmodule

// File: rtl/ysyx22041405_lsu.sv
// ysyx22041405_lsu: RV32 memory-access stage with req/gnt/rvalid bus FSM and WB output register.
// Define YSYX22041405_MISALIGN_CHK_EN to trap misaligned half/word accesses instead of issuing them.
module ysyx22041405_lsu
  import ysyx22041405_lsu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] ex_alu_result,
  input  logic [WIDTH-1:0] ex_rs2_data,
  input  logic [WIDTH-1:0] ex_pc,
  input  logic [WIDTH-1:0] ex_inst,
  input  logic             ex_mem_ren,
  input  logic             ex_mem_wen,
  input  logic [1:0]       ex_mem_size,
  input  logic             ex_mem_sext,
  input  logic             ex_rf_we,
  input  logic [4:0]       ex_rf_waddr,
  input  logic             ex_ebreak,
  output logic             mem_req,
  output logic             mem_we,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  output logic [3:0]       mem_wstrb,
  input  logic             mem_gnt,
  input  logic             mem_rvalid,
  input  logic [WIDTH-1:0] mem_rdata,
  output logic             wb_valid,
  input  logic             wb_ready,
  output logic [WIDTH-1:0] wb_data,
  output logic             wb_rf_we,
  output logic [4:0]       wb_rf_waddr,
  output logic [WIDTH-1:0] wb_pc,
  output logic [WIDTH-1:0] wb_inst,
  output logic             wb_ebreak,
  output logic             wb_misalign,
  output logic             ls_busy_rf_we,
  output logic [4:0]       ls_busy_rf_waddr
);
  lsu_state_e  state_q, state_d;
  lsu_op_t     op_q, op_d;
  wb_msg_t     wb_q, wb_d;
  logic        wb_valid_q, wb_valid_d;
  logic        accept, is_mem, mis;
  logic [31:0] ld_data;
`ifdef YSYX22041405_MISALIGN_CHK_EN
  assign mis = (ex_mem_ren | ex_mem_wen) &&
               ((ex_mem_size == MEM_H && ex_alu_result[0]) ||
                (ex_mem_size == MEM_W && ex_alu_result[1:0] != 2'b00));
`else
  assign mis = 1'b0;
`endif
  assign in_ready = state_q == IDLE && (!wb_valid_q || wb_ready);
  assign accept   = in_valid && in_ready;
  assign is_mem   = (ex_mem_ren | ex_mem_wen) && !mis;
  ysyx22041405_lsu_align u_align (
    .addr_i    (op_q.addr[1:0]),
    .size_i    (op_q.size),
    .sext_i    (op_q.sext),
    .st_data_i (op_q.wdata),
    .rdata_i   (mem_rdata),
    .wdata_o   (mem_wdata),
    .wstrb_o   (mem_wstrb),
    .ld_data_o (ld_data)
  );
  // The output register is always empty when a bus op completes: accepting it required a free slot.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    wb_d       = wb_q;
    wb_valid_d = wb_valid_q && !wb_ready;
    if (accept) begin
      op_d = '{addr: ex_alu_result, wdata: ex_rs2_data, pc: ex_pc, inst: ex_inst,
               wen: ex_mem_wen, size: ex_mem_size, sext: ex_mem_sext, rf_we: ex_rf_we,
               rf_waddr: ex_rf_waddr, ebreak: ex_ebreak};
      state_d = is_mem ? REQ : IDLE;
      if (!is_mem) begin
        wb_valid_d = 1'b1;
        wb_d = '{data: ex_alu_result, rf_we: ex_rf_we && !mis, rf_waddr: ex_rf_waddr,
                 pc: ex_pc, inst: ex_inst, ebreak: ex_ebreak, misalign: mis};
      end
    end
    if (state_q == REQ && mem_gnt) begin
      state_d = op_q.wen ? IDLE : WAIT;
      if (op_q.wen) begin
        wb_valid_d = 1'b1;
        wb_d = op_result(op_q, '0);
      end
    end
    if (state_q == WAIT && mem_rvalid) begin
      state_d    = IDLE;
      wb_valid_d = 1'b1;
      wb_d       = op_result(op_q, ld_data);
    end
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      op_q       <= '0;
      wb_q       <= '0;
      wb_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      wb_q       <= wb_d;
      wb_valid_q <= wb_valid_d;
    end
  end
  assign mem_req          = state_q == REQ;
  assign mem_we           = op_q.wen;
  assign mem_addr         = {op_q.addr[31:2], 2'b00};
  assign wb_valid         = wb_valid_q;
  assign wb_data          = wb_q.data;
  assign wb_rf_we         = wb_q.rf_we;
  assign wb_rf_waddr      = wb_q.rf_waddr;
  assign wb_pc            = wb_q.pc;
  assign wb_inst          = wb_q.inst;
  assign wb_ebreak        = wb_q.ebreak;
  assign wb_misalign      = wb_q.misalign;
  assign ls_busy_rf_we    = state_q != IDLE && op_q.rf_we;
  assign ls_busy_rf_waddr = state_q != IDLE ? op_q.rf_waddr : 5'd0;
endmodule

// File: tb/tb_ysyx22041405_lsu.sv
// tb_ysyx22041405_lsu: scoreboard bench with a byte-level reference model, bus responder and WB monitor.
module tb_ysyx22041405_lsu;
  logic clk = 0, rst = 0;
  logic in_valid = 0, in_ready;
  logic [31:0] ex_alu_result = 0, ex_rs2_data = 0, ex_pc = 0, ex_inst = 0;
  logic ex_mem_ren = 0, ex_mem_wen = 0, ex_mem_sext = 0, ex_rf_we = 0, ex_ebreak = 0;
  logic [1:0] ex_mem_size = 0;
  logic [4:0] ex_rf_waddr = 0;
  logic mem_req, mem_we, mem_gnt = 0, mem_rvalid = 0;
  logic [31:0] mem_addr, mem_wdata, mem_rdata = 0;
  logic [3:0] mem_wstrb;
  logic wb_valid, wb_ready = 1, wb_rf_we, wb_ebreak, wb_misalign, ls_busy_rf_we;
  logic [31:0] wb_data, wb_pc, wb_inst;
  logic [4:0] wb_rf_waddr, ls_busy_rf_waddr;

  ysyx22041405_lsu dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .ex_alu_result(ex_alu_result), .ex_rs2_data(ex_rs2_data), .ex_pc(ex_pc), .ex_inst(ex_inst),
    .ex_mem_ren(ex_mem_ren), .ex_mem_wen(ex_mem_wen), .ex_mem_size(ex_mem_size),
    .ex_mem_sext(ex_mem_sext), .ex_rf_we(ex_rf_we), .ex_rf_waddr(ex_rf_waddr), .ex_ebreak(ex_ebreak),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_data(wb_data), .wb_rf_we(wb_rf_we),
    .wb_rf_waddr(wb_rf_waddr), .wb_pc(wb_pc), .wb_inst(wb_inst), .wb_ebreak(wb_ebreak),
    .wb_misalign(wb_misalign), .ls_busy_rf_we(ls_busy_rf_we), .ls_busy_rf_waddr(ls_busy_rf_waddr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] alu, rs2, pc, inst;
    logic ren, wen, sext, rf_we, ebreak;
    logic [1:0] size;
    logic [4:0] waddr;
  } msg_t;
  typedef struct packed {
    logic [31:0] data; logic rf_we; logic [4:0] waddr;
    logic [31:0] pc, inst; logic ebreak, mis;
  } wbx_t;
  typedef struct packed {
    logic [31:0] addr; logic we; logic [31:0] wdata; logic [3:0] wstrb;
  } bus_t;

  int total = 0, bad = 0, cyc = 0;
  int rdy_mode = 1, gnt_fixed = 0, rv_fixed = 0;
  wbx_t exp_q[$];
  bus_t bus_q[$];
  logic [31:0] mem [logic [29:0]];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string n, logic [127:0] act, logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", n, act, exp);
    end
  endtask

  task automatic fail(string n);
    total++;
    bad++;
    $display("FAIL %s: event missing or unexpected", n);
  endtask

  function automatic logic [31:0] mem_word(logic [29:0] a);
    if (mem.exists(a)) return mem[a];
    return ({2'b00, a} * 32'h9E3779B1) ^ 32'h5A5AA5A5;
  endfunction

  // Reference: access covers n bytes starting at the address rounded down to a multiple of n.
  function automatic void model(msg_t m, output wbx_t w, output bit hb, output bus_t b);
    int n, sh;
    bit mis;
    logic [31:0] v, mask;
    n = 1 << m.size;
    mis = 0;
`ifdef YSYX22041405_MISALIGN_CHK_EN
    mis = (m.ren || m.wen) && (m.alu % n != 0);
`endif
    sh = int'(m.alu % 4) / n * n;
    w = '{data: m.alu, rf_we: m.rf_we && !mis, waddr: m.waddr, pc: m.pc, inst: m.inst,
          ebreak: m.ebreak, mis: mis};
    hb = (m.ren || m.wen) && !mis;
    b.addr = m.alu & ~32'd3;
    b.we = m.wen;
    b.wstrb = 0;
    b.wdata = 0;
    for (int i = 0; i < 4; i++) begin
      b.wstrb[i] = i >= sh && i < sh + n;
      b.wdata[8*i +: 8] = m.rs2[8*(i % n) +: 8];
    end
    if (hb && m.wen) w.data = 0;
    if (hb && m.ren) begin
      mask = n == 4 ? 32'hFFFF_FFFF : (32'd1 << (8 * n)) - 1;
      v = (mem_word(b.addr[31:2]) >> (8 * sh)) & mask;
      if (m.sext && v[8*n-1]) v = v | ~mask;
      w.data = v;
    end
  endfunction

  function automatic msg_t mk(logic [31:0] alu, logic [31:0] rs2, logic ren, logic wen,
                              logic [1:0] size, logic sext, logic rf_we, logic [4:0] wa);
    msg_t m;
    m = '{alu: alu, rs2: rs2, pc: $urandom, inst: $urandom, ren: ren, wen: wen, sext: sext,
          rf_we: rf_we, ebreak: 1'b0, size: size, waddr: wa};
    return m;
  endfunction

  task automatic send(msg_t m);
    wbx_t w;
    bus_t b;
    bit hb;
    int n = 0;
    ex_alu_result = m.alu; ex_rs2_data = m.rs2; ex_pc = m.pc; ex_inst = m.inst;
    ex_mem_ren = m.ren; ex_mem_wen = m.wen; ex_mem_size = m.size; ex_mem_sext = m.sext;
    ex_rf_we = m.rf_we; ex_rf_waddr = m.waddr; ex_ebreak = m.ebreak; in_valid = 1;
    #1;
    while (!in_ready && n < 200) begin
      @(negedge clk); #1;
      n++;
    end
    if (!in_ready) fail("send_timeout");
    else begin
      model(m, w, hb, b);
      exp_q.push_back(w);
      if (hb) bus_q.push_back(b);
    end
    @(negedge clk);
    in_valid = 0;
  endtask

  task automatic wait_idle(string n);
    int k = 0;
    while (exp_q.size() != 0 && k < 300) begin
      @(negedge clk);
      k++;
    end
    if (exp_q.size() != 0) fail(n);
  endtask

  initial forever begin
    @(posedge clk); #1;
    wb_ready = rdy_mode == 0 ? ($urandom % 4 != 0) : rdy_mode == 1;
  end

  initial begin : responder
    int req_cnt = 0, gd = 0, rd_cnt = 0;
    bit pend = 0, stray = 0;
    logic [31:0] rv_addr = 0;
    bus_t cur, prev, e;
    forever begin
      @(negedge clk);
      mem_gnt = 0; mem_rvalid = 0; mem_rdata = $urandom;
      if (!rst) begin
        pend = 0; req_cnt = 0; stray = 1;
        continue;
      end
      if (pend) begin
        if (rd_cnt == 0) begin
          mem_rvalid = 1;
          mem_rdata = mem_word(rv_addr[31:2]);
          pend = 0;
        end else rd_cnt--;
      end else if (stray || $urandom % 8 == 0) begin
        mem_rvalid = 1;
        stray = 0;
      end
      if (mem_req) begin
        cur = {mem_addr, mem_we, mem_we ? mem_wdata : 32'd0, mem_we ? mem_wstrb : 4'd0};
        if (req_cnt == 0) gd = gnt_fixed >= 0 ? gnt_fixed : int'($urandom % 4);
        else chk("req_hold", cur, prev);
        prev = cur;
        if (req_cnt == gd) begin
          mem_gnt = 1;
          req_cnt = 0;
          if (bus_q.size() == 0) fail("bus_unexpected");
          else begin
            e = bus_q.pop_front();
            chk("bus", cur, {e.addr, e.we, e.we ? e.wdata : 32'd0, e.we ? e.wstrb : 4'd0});
          end
          if (!mem_we) begin
            pend = 1;
            rd_cnt = rv_fixed >= 0 ? rv_fixed : int'($urandom % 3);
            rv_addr = mem_addr;
          end
        end else req_cnt++;
      end
    end
  end

  initial begin : monitor
    bit held = 0;
    wbx_t cur, hv;
    forever begin
      @(negedge clk); #2;
      cur = {wb_data, wb_rf_we, wb_rf_waddr, wb_pc, wb_inst, wb_ebreak, wb_misalign};
      if (!rst) held = 0;
      if (held) chk("wb_hold", cur, hv);
      held = wb_valid && !wb_ready;
      hv = cur;
      if (wb_valid && wb_ready) begin
        if (exp_q.size() == 0) fail("wb_unexpected");
        else chk("wb", cur, exp_q.pop_front());
      end
    end
  end

  initial begin
    msg_t m;
    int t0, k;
    repeat (3) @(negedge clk);
    rst = 1;
    @(negedge clk); #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_wb_valid", wb_valid, 0);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_busy", {ls_busy_rf_we, ls_busy_rf_waddr}, 0);
    chk("rst_wb_fields", {wb_data, wb_rf_we, wb_rf_waddr, wb_pc, wb_inst, wb_ebreak, wb_misalign}, 0);
    @(negedge clk);

    send(mk(32'h1234, 0, 0, 0, 0, 0, 1, 5));
    chk("alu_valid", wb_valid, 1);
    chk("alu_data", wb_data, 32'h1234);
    chk("alu_noreq", mem_req, 0);

    gnt_fixed = 3;
    send(mk(32'h8000_0003, 32'h1234_56AB, 0, 1, 0, 0, 0, 0));
    for (int i = 0; i < 4; i++) begin
      chk("st_req", mem_req, 1);
      chk("st_bus", {mem_addr, mem_wstrb, mem_wdata}, {32'h8000_0000, 4'b1000, 32'hABAB_ABAB});
      @(negedge clk);
    end
    chk("st_wb", {wb_valid, wb_data}, {1'b1, 32'd0});
    gnt_fixed = 0;

    mem[30'h2000_0000] = 32'h0000_8000;
    send(mk(32'h8000_0001, 0, 1, 0, 0, 1, 1, 7));
    chk("ld_busy", {ls_busy_rf_we, ls_busy_rf_waddr}, {1'b1, 5'd7});
    @(negedge clk);
    chk("ld_wait_novalid", wb_valid, 0);
    @(negedge clk);
    chk("ld_sext", {wb_valid, wb_data}, {1'b1, 32'hFFFF_FF80});
    send(mk(32'h8000_0001, 0, 1, 0, 0, 0, 1, 7));
    repeat (2) @(negedge clk);
    chk("ld_zext", {wb_valid, wb_data}, {1'b1, 32'h0000_0080});
    wait_idle("drain_loads");

    rdy_mode = 2;
    send(mk(32'h5555, 0, 0, 0, 0, 0, 1, 3));
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("stall_hold", {wb_valid, in_ready, wb_data}, {1'b1, 1'b0, 32'h5555});
      @(negedge clk);
    end
    rdy_mode = 1;
    @(negedge clk);
    t0 = cyc;
    for (int i = 0; i < 8; i++) send(mk(32'h100 + i, 0, 0, 0, 0, 0, 1, 5'(i)));
    chk("throughput", cyc - t0, 8);
    wait_idle("drain_stream");

    rv_fixed = 6;
    send(mk(32'h8000_0010, 0, 1, 0, 2, 0, 1, 9));
    @(negedge clk);
    chk("wait_busy", {ls_busy_rf_we, ls_busy_rf_waddr}, {1'b1, 5'd9});
    #1 rst = 0;
    exp_q.delete();
    bus_q.delete();
    @(negedge clk); #1 rst = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      chk("rst_wait", {wb_valid, mem_req, ls_busy_rf_we, in_ready}, 4'b0001);
    end
    rv_fixed = 0;

    send(mk(32'h8000_0002, 0, 1, 0, 2, 0, 1, 4));
`ifdef YSYX22041405_MISALIGN_CHK_EN
    chk("mis_trap", {mem_req, wb_valid, wb_misalign, wb_rf_we, wb_data}, {4'b0110, 32'h8000_0002});
`else
    chk("mis_word_addr", {mem_req, mem_addr}, {1'b1, 32'h8000_0000});
`endif
    wait_idle("drain_mis");

    rdy_mode = 0; gnt_fixed = -1; rv_fixed = -1;
    for (int i = 0; i < 300; i++) begin
      k = $urandom % 3;
      m = mk(32'h8000_0000 + ($urandom % 256), $urandom, k == 1, k == 2, 2'($urandom % 3),
             1'($urandom), k != 2 && ($urandom % 2 == 1), 5'($urandom));
      m.ebreak = $urandom % 16 == 0;
      send(m);
      if ($urandom % 4 == 0) @(negedge clk);
    end
    wait_idle("drain_random");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ysyx22041405_lsu.md
# ysyx22041405_lsu

Memory-access stage of the ysyx22041405 pipelined RV32 core and the consumer of the execute stage's data/control messages. It accepts one EX result per handshake, passes ALU-only instructions through in one cycle, and runs loads and stores on a request/grant/response data bus through a small FSM. Completed results are held in an output register toward the WB stage, and the block reports destination-register information for hazard detection.

## Interface
- WIDTH, 32, data/address width (only 32 supported)
- clk  input  1  system clock, all state updates on rising edge
- rst  input  1  synchronous, active-low reset (sampled on clk rising edge; 0 = reset)
- in_valid  input  1  EX message valid
- in_ready  output  1  stage can accept a message this cycle
- ex_alu_result  input  32  ALU result; effective address for loads/stores
- ex_rs2_data  input  32  store data (rf_rdata2)
- ex_pc / ex_inst  input  32 each  instruction PC and encoding, passed through
- ex_mem_ren / ex_mem_wen  input  1 each  load / store (never both set)
- ex_mem_size  input  2  0 = byte, 1 = half, 2 = word
- ex_mem_sext  input  1  sign-extend load data
- ex_rf_we  input  1  writeback enable
- ex_rf_waddr  input  5  destination register
- ex_ebreak  input  1  ebreak flag, passed through
- mem_req  output  1  bus request
- mem_we  output  1  1 = write
- mem_addr  output  32  word-aligned address ({addr[31:2],2'b00})
- mem_wdata  output  32  lane-shifted store data
- mem_wstrb  output  4  byte strobes
- mem_gnt  input  1  request accepted
- mem_rvalid  input  1  read data valid
- mem_rdata  input  32  read word
- wb_valid  output  1  result valid toward WB
- wb_ready  input  1  WB accepts the result
- wb_data  output  32  load data or ALU result
- wb_rf_we / wb_rf_waddr  output  1 / 5  writeback control
- wb_pc / wb_inst  output  32 each  passthrough fields
- wb_ebreak  output  1  passthrough flag
- wb_misalign  output  1  misaligned access flag
- ls_busy_rf_we / ls_busy_rf_waddr  output  1 / 5  destination of the instruction currently in the stage, for the hazard unit

## Operation
- FSM states are IDLE, REQ and WAIT.
- in_ready = (state==IDLE) && (!wb_valid || wb_ready).
- A message is accepted on in_valid && in_ready. All message fields are latched into an internal operation register on acceptance.
- Non-memory operation: the output register loads on the accept edge (wb_data = ex_alu_result). The FSM stays in IDLE.
- Load or store: the FSM moves IDLE→REQ. mem_req is driven from the registered state.
- In REQ, mem_req stays high with stable address, data and strobes until mem_gnt.
  - Store: on gnt, the output register loads with wb_data = 0 and the FSM returns to IDLE.
  - Load: on gnt, the FSM moves to WAIT.
- In WAIT, the FSM waits for mem_rvalid. On rvalid it extracts the lane (addr[1:0]), zero- or sign-extends per ex_mem_sext and size, loads the output register, and returns to IDLE.
- mem_rvalid outside WAIT is ignored.
- Store lanes:
  - byte: wdata = {4{b}}, wstrb = 1<<addr[1:0]
  - half: wdata = {2{h}}, wstrb = 3<<{addr[1],1'b0}
  - word: wdata = rs2, wstrb = 4'hF
- The output register holds its value while wb_valid && !wb_ready. wb_valid clears on wb_ready unless a new result loads on the same edge.
- ls_busy_* reflects the latched operation while state != IDLE, and is 0 otherwise.

## Timing
- Reset values: state = IDLE; wb_valid, mem_req, wb_misalign, ls_busy_rf_we and all wb_* fields = 0; in_ready = 1 after reset.
- Non-memory latency is 1 (accepted at edge N, wb_valid high after edge N). Back-to-back throughput is 1 per cycle while wb_ready = 1.
- Load latency with gnt in the first REQ cycle and rvalid one cycle later: accept at N; mem_req in cycle N+1; WAIT in N+2 with rvalid; wb_valid in cycle N+3.
- Store latency: wb_valid one cycle after the gnt cycle.
- Reset asserted in REQ or WAIT: the FSM returns to IDLE, mem_req drops in the next cycle, and the pending operation is discarded without a WB result.
- A simultaneous wb_ready and new accept replaces the output register in the same edge, with no bubble.

## Configuration
- YSYX22041405_MISALIGN_CHK_EN defined:
  - A half access with addr[0]=1, or a word access with addr[1:0]!=0, issues no bus request.
  - The result completes like a non-memory operation with wb_misalign = 1, wb_rf_we = 0 and wb_data = the address.
- Undefined:
  - Low address bits are ignored for word accesses; halves use addr[1] only.
  - wb_misalign is tied to 0.

## Structure
- Shared package holds:
  - size encodings (MEM_B/MEM_H/MEM_W)
  - the FSM state encoding
  - the WB message field widths used by the WB stage
- One combinational sub-module, ysyx22041405_lsu_align, holds the store lane shifting and strobe generation, plus load extraction and extension.

## Test plan
- ALU op, ex_alu_result = 0x1234, wb_ready = 1 -> wb_valid one cycle later with wb_data = 0x1234, and no mem_req.
- Store byte 0xAB to 0x8000_0003 -> mem_addr 0x8000_0000, wstrb 4'b1000, wdata 0xABABABAB; held until gnt (gnt delayed 3 cycles).
- Signed byte load from 0x...1 with rdata 0x0000_8000 -> wb_data 0xFFFF_FF80; with ex_mem_sext = 0 -> 0x0000_0080.
- wb_ready low for 4 cycles with a result pending -> wb_* stable and in_ready = 0; a back-to-back ALU stream at wb_ready = 1 -> one result per cycle.
- Reset pulse in WAIT, followed by a stray rvalid -> no wb_valid and the FSM in IDLE.
- With the macro defined, a word load to 0x...2 -> no mem_req and wb_misalign = 1; without the macro, the access goes to 0x...0.
